sig_deb_multi: RTL and testbench
================================

// Module: sig_deb_multi
// PURPOSE
//   Multi-channel, parametrised signal debouncer for switch and float-sensor inputs.
//   Each channel has three parts:
//     - synchroniser for the asynchronous input;
//     - stability counter: an input level is accepted only after it has held for STABLE_CNT clocks;
//     - edge detector giving one-cycle rise/fall pulses.
//   Sits between the board input pins and the control and status logic.
// PARAMETERS
//   CHANNELS     4      number of independent input channels (>=1)
//   CNT_W        16     stability counter width; 2**CNT_W must be >= STABLE_CNT
//   STABLE_CNT   50000  consecutive clocks a new level must hold before acceptance (>=1)
//   SYNC_STAGES  2      flops in the input synchroniser (>=2)
//   INIT_LVL     1'b0   reset value of the synchroniser flops and of sig_o
// PORTS
//   clk      in   1         system clock
//   rst_n    in   1         asynchronous reset, active-low
//   en_i     in   1         1 = debounce runs; 0 = counters hold their value, outputs frozen
//   sig_i    in   CHANNELS  raw asynchronous inputs, one bit per channel
//   sig_o    out  CHANNELS  debounced levels
//   rise_o   out  CHANNELS  one-cycle pulse when sig_o[n] goes 0->1
//   fall_o   out  CHANNELS  one-cycle pulse when sig_o[n] goes 1->0
//   chg_o    out  1         OR-reduction of rise_o | fall_o (registered)
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops=INIT_LVL, sig_o=INIT_LVL, cnt=0, rise_o=0, fall_o=0, chg_o=0.
//     Reset mid-count discards the count; no pulse is generated on reset release.
//   - Per channel n, with s = synchroniser output and en_i=1:
//       s == sig_o[n]                    : cnt <= 0 (any glitch restarts qualification)
//       s != sig_o[n], cnt <  STABLE_CNT-1 : cnt <= cnt+1
//       s != sig_o[n], cnt == STABLE_CNT-1 : sig_o[n] <= s; cnt <= 0; rise_o/fall_o[n] <= 1 for one cycle
//   - Latency: first edge at which s differs -> sig_o update = STABLE_CNT clocks.
//     Pin-to-output latency = SYNC_STAGES + STABLE_CNT clocks.
//   - Pulse timing: rise_o/fall_o assert in the same cycle sig_o changes and are 0 otherwise.
//     rise_o[n] and fall_o[n] are never high together.
//   - chg_o asserts one cycle after any rise_o/fall_o bit.
//   - STABLE_CNT=1: sig_o follows s with one clock of delay; pulses still produced.
//   - Minimum pulse spacing: toggles on the same channel are at least STABLE_CNT clocks apart.
//   - en_i=0: cnt and sig_o hold, pulses forced to 0; the synchroniser keeps sampling.
//     When en_i returns to 1, counting resumes from the held count.
//   - Channels are fully independent; simultaneous events on several channels each pulse in the same cycle.
//   - Counter never wraps: its maximum reachable value is STABLE_CNT-1.
//     Elaboration error if STABLE_CNT > 2**CNT_W or SYNC_STAGES < 2.
// STRUCTURE
//   - sig_deb_pkg.vh (shared include): default DEB_STABLE_CNT, DEB_CNT_W, DEB_SYNC_STAGES.
//     Also a clog2 function for sizing CNT_W from STABLE_CNT.
//   - Sub-module sig_deb_ch: one channel (synchroniser, counter, level and edge regs)
//     with the same parameters minus CHANNELS.
//   - Top: generate loop instantiating CHANNELS x sig_deb_ch, plus the registered chg_o OR-reduction.
// TESTING  (STABLE_CNT=4, SYNC_STAGES=2, CHANNELS=4, INIT_LVL=0, 10 ns clk)
//   1 Reset values: hold rst_n=0 with sig_i=4'hF
//       -> sig_o=0, rise_o=0, fall_o=0, chg_o=0 throughout reset.
//   2 Bounce rejection: sig_i[0] toggles every 2-3 ns for 40 ns, then settles at 1
//       -> no rise_o while bouncing; sig_o[0]=1 exactly 2+4 clocks after the last stable edge;
//          rise_o[0] high for 1 cycle; chg_o high the next cycle.
//   3 Short pulse: sig_i[1]=1 for 3 clocks, then back to 0
//       -> sig_o[1] stays 0; no pulses.
//   4 Fall path with simultaneous events: ch2 and ch3 high and settled, then both driven to 0 together
//       -> sig_o[3:2] fall in the same cycle; fall_o=4'b1100 for 1 cycle; chg_o a single 1-cycle pulse.
//   5 Enable freeze: drive sig_i[0] to a new level, drop en_i after 2 clocks, hold 10 clocks, restore en_i
//       -> no sig_o change while en_i=0; sig_o[0] updates 2 clocks after en_i returns.
//   6 Async reset mid-count: sig_i[1]=1, assert rst_n after 3 clocks, release
//       -> sig_o[1]=0 immediately; after release, qualification restarts and sig_o[1]=1 at SYNC+4 clocks.

Source files
------------

// File: rtl/sig_deb_pkg.sv
// sig_deb_pkg: shared defaults for the signal debouncer and a clog2 helper
// used to size the stability counter from the required hold time.
package sig_deb_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEB_STABLE_CNT  = 50000;
    localparam int DEB_CNT_W       = clog2(DEB_STABLE_CNT);
    localparam int DEB_SYNC_STAGES = 2;

endpackage

// File: rtl/sig_deb_ch.sv
// sig_deb_ch: one debounced channel -- input synchroniser, stability counter,
// accepted-level register and one-cycle rise/fall pulse registers.
module sig_deb_ch
    import sig_deb_pkg::*;
#(
    parameter int   CNT_W       = DEB_CNT_W,
    parameter int   STABLE_CNT  = DEB_STABLE_CNT,
    parameter int   SYNC_STAGES = DEB_SYNC_STAGES,
    parameter logic INIT_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);

    if (STABLE_CNT < 1 || SYNC_STAGES < 2 ||
        longint'(STABLE_CNT) > (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("sig_deb_ch: invalid STABLE_CNT/CNT_W/SYNC_STAGES combination");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_lvl;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_done;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s != r_lvl;
    assign w_done = w_diff && (r_cnt == CNT_W'(STABLE_CNT - 1));

    // The synchroniser keeps sampling even while debouncing is disabled.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sync <= {SYNC_STAGES{INIT_LVL}};
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_lvl  <= INIT_LVL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (en_i) begin
            r_cnt  <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
            r_lvl  <= w_done ? w_s : r_lvl;
            r_rise <= w_done && w_s;
            r_fall <= w_done && !w_s;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign sig_o  = r_lvl;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/sig_deb_multi.sv
// sig_deb_multi: CHANNELS independent debouncers plus a registered
// "something changed" flag that follows any rise/fall pulse by one cycle.
module sig_deb_multi
    import sig_deb_pkg::*;
#(
    parameter int   CHANNELS    = 4,
    parameter int   CNT_W       = DEB_CNT_W,
    parameter int   STABLE_CNT  = DEB_STABLE_CNT,
    parameter int   SYNC_STAGES = DEB_SYNC_STAGES,
    parameter logic INIT_LVL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [CHANNELS-1:0] sig_i,
    output logic [CHANNELS-1:0] sig_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                chg_o
);

    logic r_chg;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sig_deb_ch #(
            .CNT_W      (CNT_W),
            .STABLE_CNT (STABLE_CNT),
            .SYNC_STAGES(SYNC_STAGES),
            .INIT_LVL   (INIT_LVL)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (en_i),
            .sig_i (sig_i[c]),
            .sig_o (sig_o[c]),
            .rise_o(rise_o[c]),
            .fall_o(fall_o[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_chg <= 1'b0;
        else        r_chg <= |(rise_o | fall_o);

    assign chg_o = r_chg;

endmodule

// File: tb/tb_sig_deb_multi.sv
// tb_sig_deb_multi: directed bounce/enable/reset scenarios plus random stimulus,
// checked every cycle against a sliding-window reference model via a scoreboard.
module tb_sig_deb_multi;
    import sig_deb_pkg::*;

    localparam int CH = 4;
    localparam int SC = 4;
    localparam int SS = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i  = 1'b1;
    logic [CH-1:0] sig_i = '1;
    logic [CH-1:0] sig_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic          chg_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          chg;
    } obs_t;

    obs_t sb_q[$];

    sig_deb_multi #(
        .CHANNELS   (CH),
        .CNT_W      (clog2(SC)),
        .STABLE_CNT (SC),
        .SYNC_STAGES(SS),
        .INIT_LVL   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .sig_i (sig_i),
        .sig_o (sig_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .chg_o (chg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples pass through a delay line of SS clocks; a new level is
    // accepted once the last SC enabled samples all differ from the current accepted level.
    logic [CH-1:0] pin_q[$];
    logic [CH-1:0] m_lvl;
    logic          m_pulse;
    bit            win[CH][$];

    always @(posedge clk) begin : model
        logic [CH-1:0] s;
        logic [CH-1:0] r;
        logic [CH-1:0] f;
        bit            all_diff;
        r = '0;
        f = '0;
        if (!rst_n) begin
            pin_q.delete();
            repeat (SS) pin_q.push_front('0);
            m_lvl   = '0;
            m_pulse = 1'b0;
            for (int i = 0; i < CH; i++) win[i].delete();
            sb_q.push_back('0);
        end else begin
            s = pin_q[SS-1];
            pin_q.push_front(sig_i);
            void'(pin_q.pop_back());
            if (en_i) begin
                for (int i = 0; i < CH; i++) begin
                    win[i].push_back(s[i]);
                    if (win[i].size() > SC) void'(win[i].pop_front());
                    all_diff = 1'b1;
                    foreach (win[i][k]) if (win[i][k] == m_lvl[i]) all_diff = 1'b0;
                    if (win[i].size() == SC && all_diff) begin
                        m_lvl[i] = s[i];
                        r[i]     = s[i];
                        f[i]     = !s[i];
                        win[i].delete();
                    end
                end
            end
            sb_q.push_back({m_lvl, r, f, m_pulse});
            m_pulse = |(r | f);
        end
    end

    always @(negedge clk) begin : monitor
        obs_t exp_o;
        if (sb_q.size() != 0) begin
            exp_o = sb_q.pop_front();
            check("scoreboard", {19'd0, sig_o, rise_o, fall_o, chg_o}, {19'd0, exp_o});
        end
    end

    task automatic wait_lvl(input int ch, input logic val, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (sig_o[ch] === val) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [CH-1:0] acc;
        // Reset held with all inputs high
        repeat (4) @(negedge clk);
        check("reset_outputs", {sig_o, rise_o, fall_o, chg_o}, 0);
        #1;
        sig_i = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // Bounce on ch0: toggles at +2,+5,+7..+39 ns, settles high
        #1;
        #2 sig_i[0] = 1'b1;
        #3 sig_i[0] = 1'b0;
        repeat (17) #2 sig_i[0] = ~sig_i[0];
        wait_lvl(0, 1'b1, n);
        check("bounce_latency", n, SS + SC);
        check("bounce_rise", rise_o, 4'b0001);
        @(posedge clk);
        #1;
        check("bounce_chg", {rise_o, chg_o}, 5'b0000_1);
        // Short pulse on ch1
        @(negedge clk);
        #1 sig_i[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1 sig_i[1] = 1'b0;
        acc = '0;
        repeat (12) begin
            @(negedge clk);
            acc |= rise_o | fall_o;
        end
        check("short_pulse_none", {acc, sig_o[1]}, 5'b0000_0);
        // Simultaneous fall on ch2/ch3
        #1 sig_i[3:2] = 2'b11;
        repeat (10) @(negedge clk);
        check("ch23_high", sig_o[3:2], 2'b11);
        #1 sig_i[3:2] = 2'b00;
        wait_lvl(2, 1'b0, n);
        check("fall_latency", n, SS + SC);
        check("fall_both", {sig_o[3:2], fall_o, rise_o}, {2'b00, 4'b1100, 4'b0000});
        @(posedge clk);
        #1;
        check("fall_chg_on", {fall_o, chg_o}, 5'b0000_1);
        @(posedge clk);
        #1;
        check("fall_chg_off", chg_o, 1'b0);
        // Enable freeze on ch0 after two counted clocks
        @(negedge clk);
        #1 sig_i[0] = 1'b0;
        repeat (SS + 2) @(posedge clk);
        @(negedge clk);
        #1 en_i = 1'b0;
        acc = '0;
        repeat (10) begin
            @(negedge clk);
            acc |= rise_o | fall_o;
        end
        check("freeze_hold", {acc, sig_o[0]}, 5'b0000_1);
        #1 en_i = 1'b1;
        wait_lvl(0, 1'b0, n);
        check("resume_latency", n, 2);
        check("resume_fall", fall_o, 4'b0001);
        // Async reset mid-count on ch1
        @(negedge clk);
        #1 sig_i[3] = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_reset_ch3", sig_o[3], 1'b1);
        #1 sig_i[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_immediate", {sig_o, rise_o, fall_o, chg_o}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_lvl(1, 1'b1, n);
        check("post_reset_latency", n, SS + SC);
        // Random stimulus
        repeat (3000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < CH; i++) if ($urandom_range(7) == 0) sig_i[i] = ~sig_i[i];
            en_i  = $urandom_range(9) != 0;
            rst_n = $urandom_range(499) != 0;
        end
        @(negedge clk);
        #1;
        en_i  = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
